// File: rtl/mpu_matrix_streamer.sv
// Captures a DIM x DIM matrix in one cycle and drains it one element per
// valid/ready handshake in row-major order.
module mpu_matrix_streamer #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5,
  parameter int IDX_W  = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load,
  input  logic [DIM*DIM*ELEM_W-1:0]   matrix_in,
  output logic                        load_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ELEM_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_row,
  output logic [IDX_W-1:0]            out_col,
  output logic                        out_last,
  output logic                        busy,
  output logic                        overrun,
  input  logic                        error_clear
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  state_t                                state_q, state_d;
  // Packed so that element [i][j] lands at (i*DIM+j)*ELEM_W, matching matrix_in.
  logic [DIM-1:0][DIM-1:0][ELEM_W-1:0]   mat_q;
  logic [IDX_W-1:0]                      row_q, col_q, row_d, col_d;
  logic                                  hs, at_end, load_acc, ov_d;

  assign out_valid  = (state_q == STREAM);
  assign busy       = out_valid;
  assign at_end     = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign out_last   = out_valid && at_end;
  assign hs         = out_valid && out_ready;
  assign load_ready = (state_q == IDLE) || (hs && at_end);
  assign load_acc   = load && load_ready;
  // Zero while idle so a drained buffer never shows on the bus.
  assign out_data   = out_valid ? mat_q[row_q][col_q] : '0;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign ov_d       = (load && !load_ready) ? 1'b1 :
                      error_clear           ? 1'b0 : overrun;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (load_acc) begin
      state_d = STREAM;
      row_d   = '0;
      col_d   = '0;
    end else if (hs) begin
      if (at_end) begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end else if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = row_q + IDX_W'(1);
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mat_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      overrun <= ov_d;
      if (load_acc) mat_q <= matrix_in;
    end
  end

endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// Bench for mpu_matrix_streamer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mpu_matrix_streamer;
  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int IDX_W  = 3;
  localparam int MW     = DIM*DIM*ELEM_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0;
  logic [MW-1:0]     matrix_in = '0;
  logic              load_ready, out_valid, out_ready = 1'b0;
  logic [ELEM_W-1:0] out_data;
  logic [IDX_W-1:0]  out_row, out_col;
  logic              out_last, busy, overrun;
  logic              error_clear = 1'b0;

  mpu_matrix_streamer #(.ELEM_W(ELEM_W), .DIM(DIM), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset(reset), .load(load), .matrix_in(matrix_in),
    .load_ready(load_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .overrun(overrun),
    .error_clear(error_clear)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted load queues the whole matrix in row-major order.
  typedef struct {
    logic [ELEM_W-1:0] d;
    int                r;
    int                c;
  } elem_t;

  elem_t       exp_q[$];
  logic        m_ovr = 1'b0;
  int          hs_cnt = 0;
  logic [7:0]  log_q[$];

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_ovr = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);
      check("rst_row", out_row, 0);
      check("rst_col", out_col, 0);
      check("rst_ovr", overrun, 0);
      check("rst_lready", load_ready, 1);
    end else begin
      automatic logic m_vld = (exp_q.size() != 0);
      automatic logic m_hs  = m_vld && out_ready;
      automatic logic m_lr  = !m_vld || (m_hs && exp_q.size() == 1);
      check("valid", out_valid, m_vld);
      check("busy", busy, m_vld);
      check("load_ready", load_ready, m_lr);
      check("overrun", overrun, m_ovr);
      if (m_vld) begin
        check("data", out_data, exp_q[0].d);
        check("row", out_row, exp_q[0].r);
        check("col", out_col, exp_q[0].c);
        check("last", out_last, exp_q.size() == 1);
      end else begin
        check("idle_last", out_last, 0);
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        log_q.push_back(out_data);
      end
      if (m_hs) void'(exp_q.pop_front());
      if (load && m_lr) begin
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++)
            exp_q.push_back('{matrix_in[(i*DIM+j)*ELEM_W +: ELEM_W], i, j});
      end
      if (load && !m_lr) m_ovr = 1'b1;
      else if (error_clear) m_ovr = 1'b0;
    end
  end

  function automatic logic [MW-1:0] seq_mat();
    logic [MW-1:0] m;
    for (int k = 0; k < DIM*DIM; k++) m[k*ELEM_W +: ELEM_W] = ELEM_W'(k + 1);
    return m;
  endfunction

  function automatic logic [MW-1:0] fill_mat(input logic [7:0] v);
    logic [MW-1:0] m;
    for (int k = 0; k < DIM*DIM; k++) m[k*ELEM_W +: ELEM_W] = v;
    return m;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_load(input logic [MW-1:0] m);
    matrix_in = m;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  int base, hs0;
  logic [1:0] pat;

  initial begin
    tick(3);
    reset = 1'b0;
    tick();
    check("init_lready", load_ready, 1);
    check("init_valid", out_valid, 0);

    // Basic stream
    out_ready = 1'b1;
    base = log_q.size();
    do_load(seq_mat());
    check("basic_first", out_data, 1);
    tick(30);
    check("basic_hs", hs_cnt, 25);
    check("basic_log0", log_q[base], 1);
    check("basic_log24", log_q[base+24], 25);
    check("basic_end", out_valid, 0);

    // Backpressure: out_ready 1,0,0,1 repeating
    hs0 = hs_cnt;
    base = log_q.size();
    do_load(seq_mat());
    for (int k = 0; k < 120; k++) begin
      pat = 2'(k % 4);
      out_ready = (pat == 2'd0) || (pat == 2'd3);
      tick();
    end
    out_ready = 1'b1;
    check("bp_hs", hs_cnt - hs0, 25);
    check("bp_log12", log_q[base+12], 13);
    check("bp_log24", log_q[base+24], 25);

    // Back-to-back: second load during the final handshake
    do_load(seq_mat());
    tick(24);
    check("b2b_last", out_last, 1);
    check("b2b_data25", out_data, 25);
    matrix_in = fill_mat(8'hAA);
    load = 1'b1;
    #1;
    check("b2b_lready", load_ready, 1);
    tick();
    load = 1'b0;
    check("b2b_valid", out_valid, 1);
    check("b2b_data", out_data, 8'hAA);
    check("b2b_row", out_row, 0);
    check("b2b_col", out_col, 0);
    tick(30);

    // Overrun during a stream
    do_load(seq_mat());
    tick(9);
    check("ovr_beat10", out_data, 10);
    matrix_in = fill_mat(8'hFF);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("ovr_set", overrun, 1);
    check("ovr_data11", out_data, 11);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    check("ovr_clr", overrun, 0);
    load = 1'b1;
    error_clear = 1'b1;
    tick();
    load = 1'b0;
    error_clear = 1'b0;
    check("ovr_set_wins", overrun, 1);
    tick(30);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    check("ovr_final_clr", overrun, 0);

    // Capture isolation
    base = log_q.size();
    do_load(seq_mat());
    matrix_in = fill_mat(8'hFF);
    tick(30);
    check("iso_log12", log_q[base+12], 13);
    check("iso_log24", log_q[base+24], 25);

    // Reset mid-stream
    do_load(seq_mat());
    tick(6);
    check("rst_beat7", out_data, 7);
    reset = 1'b1;
    #1;
    check("rstm_valid", out_valid, 0);
    check("rstm_data", out_data, 0);
    check("rstm_row", out_row, 0);
    check("rstm_col", out_col, 0);
    tick(2);
    reset = 1'b0;
    tick(5);
    check("rstm_idle", out_valid, 0);
    do_load(seq_mat());
    check("rstm_restart_v", out_valid, 1);
    check("rstm_restart_d", out_data, 1);
    check("rstm_restart_r", out_row, 0);
    check("rstm_restart_c", out_col, 0);
    tick(30);
    check("rstm_done", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
